// File: rtl/gf2m_mul_pkg.sv
// Shared constants and FSM encoding for the 128-bit sequential carry-less multiplier.
package gf2m_mul_pkg;

    localparam int unsigned W = 128;
    localparam int unsigned H = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        MID  = 3'd2,
        HI   = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/mul_64_module.sv
// Combinational 64x64 carry-less (GF(2)[x]) multiplier, 128-bit unreduced product.
module mul_64_module (
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    output logic [127:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) begin
                p = p ^ ({64'b0, a} << i);
            end
        end
    end

endmodule

// File: rtl/mul_128_seq_ctrl.sv
// 128x128 carry-less multiply in three passes over one shared 64x64 multiplier,
// combined Karatsuba-style into a registered 256-bit product.
module mul_128_seq_ctrl
    import gf2m_mul_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] mul_out
);

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   p0;
    logic [W-1:0]   p1;
    logic [H-1:0]   mul_a;
    logic [H-1:0]   mul_b;
    logic [W-1:0]   p2;
    logic [W-1:0]   m;
    logic [2*W-1:0] comb;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            LO: begin
                mul_a = a_q[H-1:0];
                mul_b = b_q[H-1:0];
            end
            MID: begin
                mul_a = a_q[H-1:0] ^ a_q[W-1:H];
                mul_b = b_q[H-1:0] ^ b_q[W-1:H];
            end
            HI: begin
                mul_a = a_q[W-1:H];
                mul_b = b_q[W-1:H];
            end
            default: ;
        endcase
    end

    mul_64_module u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (p2)
    );

    // m is the middle term after cancelling the low and high partial products.
    always_comb begin
        m    = p0 ^ p1 ^ p2;
        comb = {p2[W-1:H], p2[H-1:0] ^ m[W-1:H], p0[W-1:H] ^ m[H-1:0], p0[H-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p0      <= '0;
            p1      <= '0;
            mul_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        busy  <= 1'b1;
                        state <= LO;
                    end
                end
                LO: begin
                    p0    <= p2;
                    state <= MID;
                end
                MID: begin
                    p1    <= p2;
                    state <= HI;
                end
                HI: begin
                    mul_out <= comb;
                    done    <= 1'b1;
                    state   <= FIN;
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
